// File: rtl/mem_arbiter.sv
// Arbitrates the icache fill path and the dcache fill/write-back path onto one memory port.
// Each line transaction takes MEM_LATENCY cycles; simultaneous requests alternate round-robin.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int MEM_LATENCY = 5,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_resp,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_resp,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  ic_grants,
    output logic [CNT_W-1:0]  dc_grants
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(MEM_LATENCY - 2);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_W / 8 - 1));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              owner_dc_q, owner_dc_d;
    logic              rr_dc_q, rr_dc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
    logic [CNT_W-1:0]  ic_grants_q, ic_grants_d;
    logic [CNT_W-1:0]  dc_grants_q, dc_grants_d;
    logic              pick_dc;

    // rr_dc_q set means the dcache wins a tie
    assign pick_dc = dc_req && (!ic_req || rr_dc_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_dc_d  = owner_dc_q;
        rr_dc_d     = rr_dc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ic_rdata_d  = ic_rdata_q;
        dc_rdata_d  = dc_rdata_q;
        ic_grants_d = ic_grants_q;
        dc_grants_d = dc_grants_q;
        case (state_q)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    state_d    = S_BUSY;
                    cnt_d      = LAT_INIT;
                    owner_dc_d = pick_dc;
                    rr_dc_d    = !pick_dc;
                    if (pick_dc) begin
                        we_d        = dc_we;
                        addr_d      = dc_addr & LINE_MASK;
                        wdata_d     = dc_wdata;
                        dc_grants_d = dc_grants_q + CNT_W'(1);
                    end else begin
                        we_d        = 1'b0;
                        addr_d      = ic_addr & LINE_MASK;
                        wdata_d     = '0;
                        ic_grants_d = ic_grants_q + CNT_W'(1);
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (owner_dc_q) dc_rdata_d = mem_rdata;
                        else            ic_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_dc_q  <= 1'b0;
            rr_dc_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            ic_grants_q <= '0;
            dc_grants_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_dc_q  <= owner_dc_d;
            rr_dc_q     <= rr_dc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
            ic_grants_q <= ic_grants_d;
            dc_grants_q <= dc_grants_d;
        end
    end

    // The counter only holds LAT_INIT in the first BUSY cycle, so it doubles as the strobe marker
    assign mem_en    = (state_q == S_BUSY) && (cnt_q == LAT_INIT);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign ic_resp   = (state_q == S_RESP) && !owner_dc_q;
    assign dc_resp   = (state_q == S_RESP) && owner_dc_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;
    assign ic_grants = ic_grants_q;
    assign dc_grants = dc_grants_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random two-requester traffic against a cycle-count transaction model and a line memory.
module tb_mem_arbiter;
    localparam int L  = 5;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req, dc_req, dc_we;
    logic [31:0]  ic_addr, dc_addr;
    logic [127:0] dc_wdata, mem_rdata;
    logic         ic_resp, dc_resp, mem_en, mem_we, busy;
    logic [127:0] ic_rdata, dc_rdata, mem_wdata;
    logic [31:0]  mem_addr;
    logic [CW-1:0] ic_grants, dc_grants;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .LINE_W(128), .MEM_LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_resp(ic_resp), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_resp(dc_resp), .dc_rdata(dc_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .ic_grants(ic_grants), .dc_grants(dc_grants)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // memory contents: environment copy written by the DUT, reference copy written by the model
    logic [127:0] env_mem [int];
    logic [127:0] ref_mem [int];

    function automatic logic [127:0] init_line(input int idx);
        logic [31:0] h;
        h = (32'(idx) * 32'h9E3779B9) ^ 32'h5A5A0000;
        return {h, ~h, h + 32'd1, h ^ 32'h0000FFFF};
    endfunction

    function automatic logic [127:0] ref_rd(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_line(idx);
    endfunction

    function automatic logic [127:0] env_rd(input int idx);
        return env_mem.exists(idx) ? env_mem[idx] : init_line(idx);
    endfunction

    // transaction-level reference model
    int           free_edge, acc, ic_cnt, dc_cnt;
    bit           active, own_dc, t_we, rr_dc;
    logic [31:0]  t_addr;
    logic [127:0] t_wdata, t_rdata, exp_ic_rd, exp_dc_rd;
    // requester drivers
    int           ic_rel, dc_rel, ic_gap, dc_gap;
    // memory strobe seen in the previous cycle
    bit           env_en, env_we;
    logic [31:0]  env_addr;
    logic [127:0] env_wdata;

    task automatic model_reset();
        free_edge = 0; acc = -100; active = 0; rr_dc = 1;
        ic_cnt = 0; dc_cnt = 0; exp_ic_rd = '0; exp_dc_rd = '0;
        ic_rel = -1; dc_rel = -1; env_en = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h100 + 32'($urandom_range(0, 7) * 16) + 32'($urandom_range(0, 15));
    endfunction

    task automatic new_ic();
        ic_req = 1'b1; ic_addr = rand_addr(); ic_rel = -1;
    endtask

    task automatic new_dc();
        dc_req = 1'b1; dc_addr = rand_addr(); dc_we = 1'($urandom_range(0, 1));
        dc_wdata = {$urandom, $urandom, $urandom, $urandom}; dc_rel = -1;
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        if (active && n == acc + L - 1 && !t_we) begin
            if (own_dc) exp_dc_rd = t_rdata;
            else        exp_ic_rd = t_rdata;
        end
        if (n >= free_edge && (ic_req || dc_req)) begin
            own_dc = dc_req && (!ic_req || rr_dc);
            rr_dc = !own_dc;
            acc = n; free_edge = n + L + 1; active = 1;
            if (own_dc) begin
                t_we = dc_we; t_addr = dc_addr; t_wdata = dc_wdata; dc_cnt++; dc_rel = n + L;
            end else begin
                t_we = 0; t_addr = ic_addr; t_wdata = '0; ic_cnt++; ic_rel = n + L;
            end
            if (t_we) ref_mem[int'(t_addr >> 4)] = t_wdata;
            else      t_rdata = ref_rd(int'(t_addr >> 4));
        end
        #1;
        if (env_en) begin
            if (env_we) env_mem[int'(env_addr >> 4)] = env_wdata;
            else        mem_rdata = env_rd(int'(env_addr >> 4));
        end
        if (ic_req) begin
            if (n == ic_rel) begin ic_req = 1'b0; ic_gap = $urandom_range(0, 4); end
        end else if (ic_gap == 0) new_ic();
        else ic_gap--;
        if (dc_req) begin
            if (n == dc_rel) begin dc_req = 1'b0; dc_gap = $urandom_range(0, 4); end
        end else if (dc_gap == 0) new_dc();
        else dc_gap--;
        @(negedge clk);
        env_en = mem_en; env_we = mem_we; env_addr = mem_addr; env_wdata = mem_wdata;
        chk("busy", busy, active && n >= acc && n <= acc + L - 1);
        chk("mem_en", mem_en, active && n == acc);
        if (active && n == acc) begin
            chk("mem_we", mem_we, t_we);
            chk("mem_addr", mem_addr, t_addr & 32'hFFFF_FFF0);
            if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end
        chk("ic_resp", ic_resp, active && !own_dc && n == acc + L - 1);
        chk("dc_resp", dc_resp, active && own_dc && n == acc + L - 1);
        chk("ic_rdata", ic_rdata, exp_ic_rd);
        chk("dc_rdata", dc_rdata, exp_dc_rd);
        chk("ic_grants", ic_grants, 128'(ic_cnt % (1 << CW)));
        chk("dc_grants", dc_grants, 128'(dc_cnt % (1 << CW)));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_mem_en"}, mem_en, 1'b0);
        chk({tag, "_resp"}, {ic_resp, dc_resp}, 2'b00);
        chk({tag, "_grants"}, {ic_grants, dc_grants}, '0);
        chk({tag, "_rdata"}, ic_rdata | dc_rdata, '0);
        chk({tag, "_mem_out"}, {mem_we, mem_addr, mem_wdata}, '0);
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h104;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
        mem_rdata = '0; ic_gap = 0; dc_gap = 3;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (300) step();

        // abandon a transaction in its third cycle
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            found = active && (n == acc + 2);
        end
        chk("reset_target_found", found, 1'b1);
        reset = 1'b1;
        #1 chk_all_zero("midreset");
        model_reset();
        ic_req = 1'b0; dc_req = 1'b0;
        #1 reset = 1'b0;
        new_ic();
        new_dc();
        repeat (300) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
